// File: rtl/ddf_pkg.sv
// Shared definitions for the one-producer / two-flux dataflow switch.
package ddf_pkg;

    localparam int DEF_WIDTH     = 8;  // data token width
    localparam int DEF_WIDTH_NDA = 8;  // control token width (only bit 0 matters)

    // CTRL: waiting for a routing token; DATA: waiting for a data token and room downstream.
    typedef enum logic {
        CTRL = 1'b0,
        DATA = 1'b1
    } state_t;

endpackage

// File: rtl/ddf_out_reg.sv
// Output register for one flux: holds the last token written and emits a
// one-cycle write strobe the cycle after a load.
import ddf_pkg::*;

module ddf_out_reg #(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             ck,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] data,
    output logic             wr
);

    // Capture the token on load; strobe follows the load by exactly one cycle.
    always_ff @(posedge ck) begin
        // NOTE: sequential state uses <= so every register samples pre-edge values.
        if (rst) begin
            data <= '0;
            wr   <= 1'b0;
        end else begin
            wr <= load;
            if (load) data <= din;
        end
    end

endmodule

// File: rtl/ddf_1p_2f_switch.sv
// Routes each data token to flux 0 or flux 1 according to bit 0 of the
// matching control token. Tokens are consumed strictly in pairs, in order.
import ddf_pkg::*;

module ddf_1p_2f_switch #(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int WIDTH_NDA = DEF_WIDTH_NDA
) (
    input  logic                 ck,
    input  logic                 rst,
    input  logic                 in_empty,
    output logic                 in_read,
    input  logic [WIDTH-1:0]     in_data,
    input  logic                 nda_empty,
    output logic                 nda_read,
    input  logic [WIDTH_NDA-1:0] nda_data,
    input  logic                 full0,
    input  logic                 full1,
    output logic                 wr0,
    output logic                 wr1,
    output logic [WIDTH-1:0]     out_data0,
    output logic [WIDTH-1:0]     out_data1
);

    state_t state;
    state_t state_nxt;
    logic   sel;
    logic   full_sel;
    logic   load0;
    logic   load1;

    // Only bit 0 of the control token steers; the upper bits are deliberately dropped.
    logic   unused_nda_bits;
    assign unused_nda_bits = ^nda_data;

    // Back-pressure only from the flux the pending token is bound for.
    assign full_sel = sel ? full1 : full0;

    // Next state and FIFO pops; reset forces both pops low.
    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        state_nxt = state;
        nda_read  = 1'b0;
        in_read   = 1'b0;
        load0     = 1'b0;
        load1     = 1'b0;
        if (!rst) begin
            case (state)
                CTRL: begin
                    if (!nda_empty) begin
                        nda_read  = 1'b1;
                        state_nxt = DATA;
                    end
                end
                DATA: begin
                    if (!in_empty && !full_sel) begin
                        in_read   = 1'b1;
                        load0     = ~sel;
                        load1     = sel;
                        state_nxt = CTRL;
                    end
                end
                default: state_nxt = CTRL;
            endcase
        end
    end

    // State register and latched routing bit.
    always_ff @(posedge ck) begin
        if (rst) begin
            state <= CTRL;
            sel   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (nda_read) sel <= nda_data[0];
        end
    end

    ddf_out_reg #(.WIDTH(WIDTH)) u_out0 (
        .ck   (ck),
        .rst  (rst),
        .load (load0),
        .din  (in_data),
        .data (out_data0),
        .wr   (wr0)
    );

    ddf_out_reg #(.WIDTH(WIDTH)) u_out1 (
        .ck   (ck),
        .rst  (rst),
        .load (load1),
        .din  (in_data),
        .data (out_data1),
        .wr   (wr1)
    );

endmodule

// File: tb/tb_ddf_1p_2f_switch.sv
// Bench for ddf_1p_2f_switch: token-level reference model with FIFO queues,
// per-flux scoreboards, directed scenarios and a randomized run.
module tb_ddf_1p_2f_switch;

    logic       ck = 1'b0;
    logic       rst = 1'b1;
    logic       in_empty = 1'b1;
    logic       in_read;
    logic [7:0] in_data = '0;
    logic       nda_empty = 1'b1;
    logic       nda_read;
    logic [7:0] nda_data = '0;
    logic       full0 = 1'b0;
    logic       full1 = 1'b0;
    logic       wr0;
    logic       wr1;
    logic [7:0] out_data0;
    logic [7:0] out_data1;

    ddf_1p_2f_switch dut (
        .ck        (ck),
        .rst       (rst),
        .in_empty  (in_empty),
        .in_read   (in_read),
        .in_data   (in_data),
        .nda_empty (nda_empty),
        .nda_read  (nda_read),
        .nda_data  (nda_data),
        .full0     (full0),
        .full1     (full1),
        .wr0       (wr0),
        .wr1       (wr1),
        .out_data0 (out_data0),
        .out_data1 (out_data1)
    );

    always #5 ck = ~ck;

    // Upstream FIFOs and per-flux expected streams.
    logic [7:0] ctrl_q[$];
    logic [7:0] data_q[$];
    logic [7:0] exp0_q[$];
    logic [7:0] exp1_q[$];
    int         wr_times[$];

    // Token-level model state.
    bit         have_ctrl = 0;
    bit         ctrl_port = 0;
    bit         pend_wr   = 0;
    bit         pend_port = 0;
    logic [7:0] out_exp0  = '0;
    logic [7:0] out_exp1  = '0;

    bit rst_req = 1;
    bit rnd     = 0;
    int f0_hold = 0;
    int f1_hold = 0;
    int cyc     = 0;
    int n_nda   = 0;
    int n_in    = 0;
    int last_nda_cyc = -1;
    int last_in_cyc  = -1;
    int last_wr0_cyc = -1;
    int last_wr1_cyc = -1;
    int n_wr1   = 0;

    int n_vec  = 0;
    int n_miss = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic bit busy();
        return (ctrl_q.size() != 0) || (data_q.size() != 0) || have_ctrl || pend_wr;
    endfunction

    task automatic push_tok(input logic [7:0] c, input logic [7:0] d);
        ctrl_q.push_back(c);
        data_q.push_back(d);
        if (c[0]) exp1_q.push_back(d);
        else      exp0_q.push_back(d);
    endtask

    // One clock: drive at negedge, observe #1 later, advance the model.
    task automatic cycle();
        bit exp_w0, exp_w1, exp_nda, exp_in, f_sel;
        @(negedge ck);
        cyc++;
        rst       = rst_req;
        nda_empty = (ctrl_q.size() == 0) || (rnd && $urandom_range(0, 3) == 0);
        nda_data  = nda_empty ? 8'($urandom) : ctrl_q[0];
        in_empty  = (data_q.size() == 0) || (rnd && $urandom_range(0, 3) == 0);
        in_data   = in_empty ? 8'($urandom) : data_q[0];
        full0     = (f0_hold > 0) || (rnd && $urandom_range(0, 2) == 0);
        full1     = (f1_hold > 0) || (rnd && $urandom_range(0, 2) == 0);
        if (f0_hold > 0) f0_hold--;
        if (f1_hold > 0) f1_hold--;
        #1;

        // Registered side: result of the previous edge.
        exp_w0 = pend_wr && !pend_port;
        exp_w1 = pend_wr && pend_port;
        if (exp_w0) out_exp0 = (exp0_q.size() != 0) ? exp0_q.pop_front() : 8'h00;
        if (exp_w1) out_exp1 = (exp1_q.size() != 0) ? exp1_q.pop_front() : 8'h00;
        check("wr0", wr0, exp_w0);
        check("wr1", wr1, exp_w1);
        check("out_data0", out_data0, out_exp0);
        check("out_data1", out_data1, out_exp1);
        if (wr0) begin last_wr0_cyc = cyc; wr_times.push_back(cyc); end
        if (wr1) begin last_wr1_cyc = cyc; wr_times.push_back(cyc); n_wr1++; end

        // Combinational side: pops for this cycle.
        f_sel   = ctrl_port ? full1 : full0;
        exp_nda = !rst && !have_ctrl && !nda_empty;
        exp_in  = !rst && have_ctrl && !in_empty && !f_sel;
        check("nda_read", nda_read, exp_nda);
        check("in_read", in_read, exp_in);
        check("read_excl", in_read & nda_read, 0);
        if (nda_read) begin last_nda_cyc = cyc; n_nda++; end
        if (in_read)  begin last_in_cyc  = cyc; n_in++;  end

        // Upstream FIFOs pop on what the DUT actually asserted.
        if (nda_read && !nda_empty && ctrl_q.size() != 0) void'(ctrl_q.pop_front());
        if (in_read && !in_empty && data_q.size() != 0)   void'(data_q.pop_front());

        // Model update for the coming edge.
        if (rst) begin
            have_ctrl = 0;
            pend_wr   = 0;
            out_exp0  = '0;
            out_exp1  = '0;
        end else begin
            pend_wr   = exp_in;
            pend_port = ctrl_port;
            if (exp_nda) begin
                have_ctrl = 1;
                ctrl_port = nda_data[0];
            end else if (exp_in) begin
                have_ctrl = 0;
            end
        end
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (busy() && n < budget) begin
            cycle();
            n++;
        end
        if (busy()) check("drain_timeout", 1, 0);
    endtask

    initial begin
        int base;
        int bal;

        // Reset state.
        rst_req = 1;
        run_cycles(2);
        rst_req = 0;
        run_cycles(1);

        // Single token to flux 0: pop ctrl at 0, data at 1, write visible at 2.
        base = cyc + 1;
        push_tok(8'h00, 8'hA5);
        drain(20);
        check("lat_nda", last_nda_cyc - base, 0);
        check("lat_in", last_in_cyc - base, 1);
        check("lat_wr0", last_wr0_cyc - base, 2);
        check("no_wr1", n_wr1, 0);
        check("first_out0", out_data0, 8'hA5);

        // Sequence 1,0,1: in order, writes two cycles apart.
        wr_times.delete();
        push_tok(8'h01, 8'h11);
        push_tok(8'h00, 8'h22);
        push_tok(8'h01, 8'h33);
        drain(40);
        check("seq_writes", wr_times.size(), 3);
        if (wr_times.size() == 3) begin
            check("seq_gap0", wr_times[1] - wr_times[0], 2);
            check("seq_gap1", wr_times[2] - wr_times[1], 2);
        end
        check("seq_out1", out_data1, 8'h33);
        check("seq_out0", out_data0, 8'h22);

        // Stall on flux 1 for 5 cycles; full0 stays low and must not matter.
        base = cyc + 1;
        f1_hold = 5;
        push_tok(8'h01, 8'h5A);
        drain(40);
        check("stall_wr1", last_wr1_cyc - base, 6);
        check("stall_out1", out_data1, 8'h5A);

        // Upper control bits ignored.
        push_tok(8'hFE, 8'h3C);
        drain(20);
        check("bit0_out0", out_data0, 8'h3C);

        // Randomized run: 1000 tokens with random empty/full toggling.
        bal = n_nda - n_in;
        rnd = 1;
        for (int i = 0; i < 1000; i++) push_tok(8'($urandom), 8'($urandom));
        drain(30000);
        rnd = 0;
        check("sb0_left", exp0_q.size(), 0);
        check("sb1_left", exp1_q.size(), 0);
        check("tok_balance", n_nda - n_in, bal);

        // Reset while in DATA with data available: the popped control token is lost.
        ctrl_q.push_back(8'h01);
        run_cycles(2);
        data_q.push_back(8'h77);
        rst_req = 1;
        run_cycles(1);
        rst_req = 0;
        data_q.delete();
        run_cycles(1);
        check("rst_out0", out_data0, 8'h00);
        check("rst_out1", out_data1, 8'h00);
        base = cyc + 1;
        push_tok(8'h01, 8'h99);
        drain(20);
        check("restart_nda", last_nda_cyc - base, 0);
        check("restart_wr1", last_wr1_cyc - base, 2);
        check("restart_out1", out_data1, 8'h99);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
